ibex_rvfi_trace_buffer: RTL
===========================

// Module: ibex_rvfi_trace_buffer
// PURPOSE
//  On-chip capture buffer for RVFI retirement records; sits beside ibex_core next to ibex_tracer.
//  Two modes: FIFO streaming (drop-newest on full) and ring with trigger + post-trigger freeze.
//  Gives silicon/FPGA builds a trace window without the simulation-only text tracer.
// PARAMETERS
//  Depth        16  record slots; power of 2, >=2
//  PostTrigger  8   records captured after the trigger record (ring mode); 0 <= PostTrigger < Depth
//  CaptureMem   1   1: record includes mem_addr; 0: that field is tied 0 and not stored
// PORTS
//  clk_i            in   1    clock
//  rst_ni           in   1    async reset, active low
//  rvfi_valid_i     in   1    retirement strobe
//  rvfi_insn_i      in   32   instruction word
//  rvfi_trap_i      in   1    instruction trapped
//  rvfi_intr_i      in   1    first insn of trap handler
//  rvfi_mode_i      in   2    privilege mode
//  rvfi_rd_addr_i   in   5    destination register
//  rvfi_rd_wdata_i  in   32   rd write data
//  rvfi_pc_rdata_i  in   32   PC of retired insn
//  rvfi_mem_addr_i  in   32   memory address
//  cfg_enable_i     in   1    capture enable
//  cfg_mode_i       in   1    0 FIFO, 1 RING; latched on IDLE->ARMED
//  cfg_clear_i      in   1    sync clear of buffer, counters, trigger
//  cfg_trig_trap_i  in   1    trigger on rvfi_trap_i
//  cfg_trig_pc_en_i in   1    trigger on PC match
//  cfg_trig_pc_i    in   32   trigger PC
//  rd_valid_o       out  1    record available
//  rd_ready_i       in   1    consumer pop
//  rd_rec_o         out  RecW oldest record (trace_rec_t)
//  count_o          out  $clog2(Depth+1)  occupied slots
//  triggered_o      out  1    trigger seen since clear
//  frozen_o         out  1    ring capture finished
//  overflow_o       out  16   dropped records, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset: state IDLE, pointers/count 0, all outputs 0, latched mode FIFO.
//  FSM: IDLE -(enable)-> ARMED -(trigger, ring)-> POST -(post_cnt==0 after capture)-> FROZEN.
//   PostTrigger==0: ARMED -> FROZEN directly on the trigger record.
//   Any state -(!enable)-> IDLE; contents kept. FROZEN -> ARMED only via clear while enabled.
//  Capture: rvfi_valid_i in ARMED/POST writes record at wr_ptr; visible on rd_* next cycle (latency 1).
//  Trigger = valid & ((cfg_trig_trap_i & trap) | (cfg_trig_pc_en_i & pc==cfg_trig_pc_i)).
//   Trigger record is itself captured. In POST, post_cnt loads PostTrigger and decrements per capture.
//   Triggers in POST/FROZEN are ignored. FIFO mode: triggered_o sets; no state change.
//  FIFO mode full: new record dropped, overflow_o++. Same-cycle pop + push on full: both accepted.
//  Ring mode full: oldest overwritten (rd_ptr advances); overflow_o not incremented.
//  Readout: FIFO/IDLE: rd_valid_o = count>0. RING+ARMED/POST: rd_valid_o=0 (no pops mid-window).
//   Pop on rd_valid_o & rd_ready_i; rd_rec_o stable while rd_valid_o & !rd_ready_i.
//  Pointers log2(Depth) bits, wrap naturally; count tracks separately; count never exceeds Depth.
//  cfg_clear_i: next cycle count/pointers/overflow/triggered/frozen 0, state ARMED if enable else IDLE;
//   clear wins over same-cycle capture and pop.
//  cfg_mode_i changes outside IDLE are ignored.
// STRUCTURE
//  ibex_trace_pkg: trace_rec_t (packed pc, insn, rd_addr, rd_wdata, mem_addr, trap, intr, mode),
//   trace_state_e {IDLE, ARMED, POST, FROZEN}, trace_mode_e {TRACE_FIFO, TRACE_RING}.
//  Sub-module ibex_trace_buf_mem: Depth x RecW flop array, 1 write/1 read port, no reset on data.
//  Assertions: Depth pow2, PostTrigger<Depth, count<=Depth, no pop when !rd_valid_o.
// TESTING
//  FIFO, Depth=16: 20 retirements, rd_ready_i=0 -> count_o=16, overflow_o=4, rd_rec_o.pc = 1st PC.
//  FIFO full, push+pop same cycle -> count_o stays 16, overflow_o unchanged, new record at tail.
//  RING, trig PC 0x80: PCs 0x00..0x7C, 0x80, then 12 more -> frozen_o=1 after 8th post rec, count 16,
//   oldest = PC 0x80-7*4=0x64, 4 remaining retirements ignored.
//  RING, PostTrigger=0, trap on 3rd retirement -> FROZEN same cycle+1, count_o=3, rd_valid_o=1.
//  Clear asserted with rvfi_valid_i and rd_ready_i high -> next cycle count_o=0, overflow_o=0, ARMED.
//  Reset mid-POST (rst_ni low 1 cycle) -> all outputs 0, IDLE; re-enable restarts capture from slot 0.

Source files
------------

// File: rtl/ibex_trace_pkg.sv
// Shared types for the RVFI trace capture buffer: record layout, FSM states and capture modes.
package ibex_trace_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic        trap;
        logic        intr;
        logic [1:0]  mode;
    } trace_rec_t;

    localparam int unsigned RecW      = $bits(trace_rec_t);
    localparam int unsigned RecNoMemW = RecW - 32;

    typedef enum logic [1:0] {IDLE, ARMED, POST, FROZEN} trace_state_e;
    typedef enum logic {TRACE_FIFO, TRACE_RING} trace_mode_e;

    // Storage format when mem_addr is not captured.
    function automatic logic [RecNoMemW-1:0] pack_no_mem(input trace_rec_t r);
        return {r.pc, r.insn, r.rd_addr, r.rd_wdata, r.trap, r.intr, r.mode};
    endfunction

    function automatic trace_rec_t unpack_no_mem(input logic [RecNoMemW-1:0] v);
        trace_rec_t r;
        {r.pc, r.insn, r.rd_addr, r.rd_wdata, r.trap, r.intr, r.mode} = v;
        r.mem_addr = '0;
        return r;
    endfunction

endpackage

// File: rtl/ibex_rvfi_trace_buffer_if.sv
// RVFI retirement bus as seen by the trace buffer; the core side drives, the buffer listens.
interface ibex_rvfi_trace_buffer_if;
    logic        valid;
    logic [31:0] insn;
    logic        trap;
    logic        intr;
    logic [1:0]  mode;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] mem_addr;

    modport master (
        output valid, insn, trap, intr, mode, rd_addr, rd_wdata, pc_rdata, mem_addr
    );
    modport slave (
        input valid, insn, trap, intr, mode, rd_addr, rd_wdata, pc_rdata, mem_addr
    );
endinterface

// File: rtl/ibex_trace_buf_mem.sv
// Record storage: flop array with one write port and one asynchronous read port, data not reset.
module ibex_trace_buf_mem #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] waddr_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic [$clog2(Depth)-1:0] raddr_i,
    output logic [Width-1:0]         rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// On-chip RVFI retirement capture: FIFO streaming (drop newest when full) or triggered ring
// capture that freezes PostTrigger records after the trigger.
module ibex_rvfi_trace_buffer
    import ibex_trace_pkg::*;
#(
    parameter int unsigned Depth       = 16,
    parameter int unsigned PostTrigger = 8,
    parameter bit          CaptureMem  = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    ibex_rvfi_trace_buffer_if.slave    rvfi,
    input  logic                       cfg_enable_i,
    input  logic                       cfg_mode_i,
    input  logic                       cfg_clear_i,
    input  logic                       cfg_trig_trap_i,
    input  logic                       cfg_trig_pc_en_i,
    input  logic [31:0]                cfg_trig_pc_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output trace_rec_t                 rd_rec_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       triggered_o,
    output logic                       frozen_o,
    output logic [15:0]                overflow_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned MemW = CaptureMem ? RecW : RecNoMemW;

    trace_state_e    state_q, state_d;
    trace_mode_e     mode_q, mode_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, post_cnt_q, post_cnt_d;
    logic [CntW-1:0] count_q, count_d;
    logic [15:0]     overflow_q, overflow_d;
    logic            triggered_q, triggered_d, frozen_q, frozen_d;

    logic ring, full, hit, capture, pop, we, overwrite, drop;

    trace_rec_t      wr_rec, mem_rec;
    logic [MemW-1:0] mem_wdata, mem_rdata;

    assign ring = (mode_q == TRACE_RING);
    assign full = (count_q == CntW'(Depth));
    assign hit  = rvfi.valid & ((cfg_trig_trap_i & rvfi.trap) |
                                (cfg_trig_pc_en_i & (rvfi.pc_rdata == cfg_trig_pc_i)));

    // Ring readout is blocked while the capture window is still open.
    assign rd_valid_o = (count_q != '0) & ~(ring & ((state_q == ARMED) | (state_q == POST)));

    assign capture   = rvfi.valid & cfg_enable_i & ~cfg_clear_i &
                       ((state_q == ARMED) | (state_q == POST));
    assign pop       = rd_valid_o & rd_ready_i & ~cfg_clear_i;
    assign we        = capture & (ring | ~full | pop);
    assign overwrite = capture & ring & full;
    assign drop      = capture & ~ring & full & ~pop;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        post_cnt_d  = post_cnt_q;
        overflow_d  = overflow_q;
        triggered_d = triggered_q;

        if (we) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop || overwrite) rd_ptr_d = rd_ptr_q + 1'b1;
        if (we && !overwrite && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !we) begin
            count_d = count_q - 1'b1;
        end
        if (drop && (overflow_q != 16'hFFFF)) overflow_d = overflow_q + 16'd1;

        if (!cfg_enable_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARMED;
                    mode_d  = trace_mode_e'(cfg_mode_i);
                end
                ARMED: begin
                    if (capture && hit) begin
                        triggered_d = 1'b1;
                        if (ring) begin
                            if (PostTrigger == 0) begin
                                state_d = FROZEN;
                            end else begin
                                state_d    = POST;
                                post_cnt_d = PtrW'(PostTrigger);
                            end
                        end
                    end
                end
                POST: begin
                    if (capture) begin
                        post_cnt_d = post_cnt_q - 1'b1;
                        if (post_cnt_q == PtrW'(1)) state_d = FROZEN;
                    end
                end
                FROZEN: ;
            endcase
        end

        // Clear overrides everything computed above, including this cycle's capture and pop.
        if (cfg_clear_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            post_cnt_d  = '0;
            overflow_d  = '0;
            triggered_d = 1'b0;
            state_d     = cfg_enable_i ? ARMED : IDLE;
            mode_d      = (cfg_enable_i && (state_q == IDLE)) ? trace_mode_e'(cfg_mode_i) : mode_q;
        end

        frozen_d = (state_d == FROZEN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mode_q      <= TRACE_FIFO;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            post_cnt_q  <= '0;
            overflow_q  <= '0;
            triggered_q <= 1'b0;
            frozen_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            post_cnt_q  <= post_cnt_d;
            overflow_q  <= overflow_d;
            triggered_q <= triggered_d;
            frozen_q    <= frozen_d;
        end
    end

    assign wr_rec = '{pc: rvfi.pc_rdata, insn: rvfi.insn, rd_addr: rvfi.rd_addr,
                      rd_wdata: rvfi.rd_wdata, mem_addr: rvfi.mem_addr, trap: rvfi.trap,
                      intr: rvfi.intr, mode: rvfi.mode};

    if (CaptureMem) begin : g_mem_addr
        assign mem_wdata = wr_rec;
        assign mem_rec   = mem_rdata;
    end else begin : g_no_mem_addr
        assign mem_wdata = pack_no_mem(wr_rec);
        assign mem_rec   = unpack_no_mem(mem_rdata);
    end

    ibex_trace_buf_mem #(
        .Depth (Depth),
        .Width (MemW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (mem_wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    assign rd_rec_o    = rd_valid_o ? mem_rec : '0;
    assign count_o     = count_q;
    assign triggered_o = triggered_q;
    assign frozen_o    = frozen_q;
    assign overflow_o  = overflow_q;

    a_depth_pow2: assert property (@(posedge clk_i)
        ((Depth & (Depth - 1)) == 0) && (Depth >= 2));
    a_post_lt_depth: assert property (@(posedge clk_i) PostTrigger < Depth);
    a_count_le_depth: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CntW'(Depth));
    a_no_pop_invalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop |-> rd_valid_o);

endmodule
